// File: rtl/axi_mem_slave_model.sv
// rtl/axi_mem_slave_model.sv - parametrised AXI3-style slave memory model with AW/AR/B queues.
// Optional random stalls via AXI_MEM_RAND_STALL_EN (16-bit LFSR gating of ready/valid).
module axi_mem_slave_model #(
  parameter int DATA_W         = 64,
  parameter int ADDR_W         = 32,
  parameter int ID_W           = 6,
  parameter int MEM_WORDS_LOG2 = 20,
  parameter int AR_DEPTH_LOG2  = 3,
  parameter int AW_DEPTH_LOG2  = 3,
  parameter int RD_LATENCY     = 2
) (
  input  logic                m_axi_clk,
  input  logic                m_axi_rst,
  input  logic [ID_W-1:0]     m_axi_awid,
  input  logic [ADDR_W-1:0]   m_axi_awaddr,
  input  logic [3:0]          m_axi_awlen,
  input  logic                m_axi_awvalid,
  output logic                m_axi_awready,
  input  logic [DATA_W-1:0]   m_axi_wdata,
  input  logic [DATA_W/8-1:0] m_axi_wstrb,
  input  logic                m_axi_wlast,
  input  logic                m_axi_wvalid,
  output logic                m_axi_wready,
  output logic [ID_W-1:0]     m_axi_bid,
  output logic [1:0]          m_axi_bresp,
  output logic                m_axi_bvalid,
  input  logic                m_axi_bready,
  input  logic [ID_W-1:0]     m_axi_arid,
  input  logic [ADDR_W-1:0]   m_axi_araddr,
  input  logic [3:0]          m_axi_arlen,
  input  logic                m_axi_arvalid,
  output logic                m_axi_arready,
  output logic [ID_W-1:0]     m_axi_rid,
  output logic [DATA_W-1:0]   m_axi_rdata,
  output logic [1:0]          m_axi_rresp,
  output logic                m_axi_rlast,
  output logic                m_axi_rvalid,
  input  logic                m_axi_rready,
  output logic                err_wlast,
  output logic [31:0]         rd_beats,
  output logic [31:0]         wr_beats
);
  localparam int STRB_W   = DATA_W / 8;
  localparam int BYTE_SH  = $clog2(STRB_W);
  localparam int AR_DEPTH = 1 << AR_DEPTH_LOG2;
  localparam int AW_DEPTH = 1 << AW_DEPTH_LOG2;
  localparam logic [3:0] LAT_INIT = 4'(RD_LATENCY);
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DATA_W-1:0] mem [0:(1<<MEM_WORDS_LOG2)-1];

  // Readies come up one cycle after reset release; valids are masked during reset too.
  logic rdy_en;
  always_ff @(posedge m_axi_clk) begin
    if (m_axi_rst) rdy_en <= 1'b0;
    else           rdy_en <= 1'b1;
  end

  // AW queue
  logic [ID_W-1:0]        aw_id_q   [0:AW_DEPTH-1];
  logic [ADDR_W-1:0]      aw_addr_q [0:AW_DEPTH-1];
  logic [3:0]             aw_len_q  [0:AW_DEPTH-1];
  logic [AW_DEPTH_LOG2:0] aw_wr_ptr, aw_rd_ptr;
  logic [AW_DEPTH_LOG2-1:0] aw_head;
  logic aw_empty, aw_full, aw_push, aw_pop;

  assign aw_head  = aw_rd_ptr[AW_DEPTH_LOG2-1:0];
  assign aw_empty = (aw_wr_ptr == aw_rd_ptr);
  assign aw_full  = (aw_wr_ptr[AW_DEPTH_LOG2] != aw_rd_ptr[AW_DEPTH_LOG2]) &&
                    (aw_wr_ptr[AW_DEPTH_LOG2-1:0] == aw_rd_ptr[AW_DEPTH_LOG2-1:0]);
  assign aw_push  = m_axi_awvalid && m_axi_awready;

  // B queue, same depth as AW
  logic [ID_W-1:0]        b_id_q   [0:AW_DEPTH-1];
  logic [1:0]             b_resp_q [0:AW_DEPTH-1];
  logic [AW_DEPTH_LOG2:0] b_wr_ptr, b_rd_ptr;
  logic b_empty, b_full, b_push, b_pop;

  assign b_empty = (b_wr_ptr == b_rd_ptr);
  assign b_full  = (b_wr_ptr[AW_DEPTH_LOG2] != b_rd_ptr[AW_DEPTH_LOG2]) &&
                   (b_wr_ptr[AW_DEPTH_LOG2-1:0] == b_rd_ptr[AW_DEPTH_LOG2-1:0]);

  // AR queue
  logic [ID_W-1:0]        ar_id_q   [0:AR_DEPTH-1];
  logic [ADDR_W-1:0]      ar_addr_q [0:AR_DEPTH-1];
  logic [3:0]             ar_len_q  [0:AR_DEPTH-1];
  logic [AR_DEPTH_LOG2:0] ar_wr_ptr, ar_rd_ptr, ar_cnt;
  logic [AR_DEPTH_LOG2-1:0] ar_head;
  logic ar_empty, ar_full, ar_push, ar_pop;

  assign ar_head  = ar_rd_ptr[AR_DEPTH_LOG2-1:0];
  assign ar_cnt   = ar_wr_ptr - ar_rd_ptr;
  assign ar_empty = (ar_wr_ptr == ar_rd_ptr);
  assign ar_full  = (ar_wr_ptr[AR_DEPTH_LOG2] != ar_rd_ptr[AR_DEPTH_LOG2]) &&
                    (ar_wr_ptr[AR_DEPTH_LOG2-1:0] == ar_rd_ptr[AR_DEPTH_LOG2-1:0]);
  assign ar_push  = m_axi_arvalid && m_axi_arready;

  // Write datapath
  logic [3:0]        w_off;
  logic              w_err;
  logic [ADDR_W-1:0] w_idx;
  logic              w_in_range, w_is_last, w_hs, wready_base;
  logic [1:0]        w_resp;

  assign w_idx       = (aw_addr_q[aw_head] >> BYTE_SH) + ADDR_W'(w_off);
  assign w_in_range  = (w_idx[ADDR_W-1:MEM_WORDS_LOG2] == '0);
  assign w_is_last   = (w_off == aw_len_q[aw_head]);
  assign wready_base = rdy_en && !aw_empty && !(b_full && w_is_last);
  assign w_hs        = m_axi_wvalid && m_axi_wready;
  assign aw_pop      = w_hs && w_is_last;
  assign b_push      = aw_pop;
  assign w_resp      = (w_err || !w_in_range) ? RESP_SLVERR : RESP_OKAY;

  assign m_axi_bvalid = rdy_en && !b_empty;
  assign m_axi_bid    = b_id_q[b_rd_ptr[AW_DEPTH_LOG2-1:0]];
  assign m_axi_bresp  = b_resp_q[b_rd_ptr[AW_DEPTH_LOG2-1:0]];
  assign b_pop        = m_axi_bvalid && m_axi_bready;

  // Read datapath
  logic [3:0]        r_off, lat_cnt;
  logic [ADDR_W-1:0] r_idx;
  logic              r_in_range, rvalid_base, r_hs, r_hold;
  logic [DATA_W-1:0] mem_rd, r_hold_data;

  assign r_idx       = (ar_addr_q[ar_head] >> BYTE_SH) + ADDR_W'(r_off);
  assign r_in_range  = (r_idx[ADDR_W-1:MEM_WORDS_LOG2] == '0);
  assign rvalid_base = rdy_en && !ar_empty && (lat_cnt == 4'd0);
  assign mem_rd      = r_in_range ? mem[r_idx[MEM_WORDS_LOG2-1:0]] : '0;
  // A stalled beat keeps the data it first presented, even if that word is rewritten.
  assign m_axi_rdata = r_hold ? r_hold_data : mem_rd;
  assign m_axi_rresp = r_in_range ? RESP_OKAY : RESP_SLVERR;
  assign m_axi_rid   = ar_id_q[ar_head];
  assign m_axi_rlast = m_axi_rvalid && (r_off == ar_len_q[ar_head]);
  assign r_hs        = m_axi_rvalid && m_axi_rready;
  assign ar_pop      = r_hs && m_axi_rlast;

`ifdef AXI_MEM_RAND_STALL_EN
  logic [15:0] lfsr;
  logic        r_shown;
  always_ff @(posedge m_axi_clk) begin
    if (m_axi_rst) begin
      lfsr    <= 16'hACE1;
      r_shown <= 1'b0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (r_hs)              r_shown <= 1'b0;
      else if (m_axi_rvalid) r_shown <= 1'b1;
    end
  end
  assign m_axi_arready = rdy_en && !ar_full && lfsr[0];
  assign m_axi_awready = rdy_en && !aw_full && lfsr[3];
  assign m_axi_wready  = wready_base && lfsr[7];
  assign m_axi_rvalid  = rvalid_base && (r_shown || lfsr[11]);
`else
  assign m_axi_arready = rdy_en && !ar_full;
  assign m_axi_awready = rdy_en && !aw_full;
  assign m_axi_wready  = wready_base;
  assign m_axi_rvalid  = rvalid_base;
`endif

  always_ff @(posedge m_axi_clk) begin
    if (m_axi_rst) begin
      aw_wr_ptr <= '0;
      aw_rd_ptr <= '0;
      b_wr_ptr  <= '0;
      b_rd_ptr  <= '0;
      ar_wr_ptr <= '0;
      ar_rd_ptr <= '0;
    end else begin
      if (aw_push) aw_wr_ptr <= aw_wr_ptr + 1'b1;
      if (aw_pop)  aw_rd_ptr <= aw_rd_ptr + 1'b1;
      if (b_push)  b_wr_ptr  <= b_wr_ptr + 1'b1;
      if (b_pop)   b_rd_ptr  <= b_rd_ptr + 1'b1;
      if (ar_push) ar_wr_ptr <= ar_wr_ptr + 1'b1;
      if (ar_pop)  ar_rd_ptr <= ar_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge m_axi_clk) begin
    if (aw_push) begin
      aw_id_q[aw_wr_ptr[AW_DEPTH_LOG2-1:0]]   <= m_axi_awid;
      aw_addr_q[aw_wr_ptr[AW_DEPTH_LOG2-1:0]] <= m_axi_awaddr;
      aw_len_q[aw_wr_ptr[AW_DEPTH_LOG2-1:0]]  <= m_axi_awlen;
    end
    if (b_push) begin
      b_id_q[b_wr_ptr[AW_DEPTH_LOG2-1:0]]   <= aw_id_q[aw_head];
      b_resp_q[b_wr_ptr[AW_DEPTH_LOG2-1:0]] <= w_resp;
    end
    if (ar_push) begin
      ar_id_q[ar_wr_ptr[AR_DEPTH_LOG2-1:0]]   <= m_axi_arid;
      ar_addr_q[ar_wr_ptr[AR_DEPTH_LOG2-1:0]] <= m_axi_araddr;
      ar_len_q[ar_wr_ptr[AR_DEPTH_LOG2-1:0]]  <= m_axi_arlen;
    end
    if (m_axi_rvalid && !r_hold) r_hold_data <= mem_rd;
  end

  // Memory is deliberately outside reset so contents survive it.
  always_ff @(posedge m_axi_clk) begin
    if (w_hs && w_in_range && !m_axi_rst) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (m_axi_wstrb[b])
          mem[w_idx[MEM_WORDS_LOG2-1:0]][b*8 +: 8] <= m_axi_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge m_axi_clk) begin
    if (m_axi_rst) begin
      w_off     <= '0;
      w_err     <= 1'b0;
      err_wlast <= 1'b0;
      r_off     <= '0;
      lat_cnt   <= '0;
      r_hold    <= 1'b0;
      rd_beats  <= '0;
      wr_beats  <= '0;
    end else begin
      if (w_hs) begin
        wr_beats <= wr_beats + 32'd1;
        if (m_axi_wlast != w_is_last) err_wlast <= 1'b1;
        if (w_is_last) begin
          w_off <= '0;
          w_err <= 1'b0;
        end else begin
          w_off <= w_off + 4'd1;
          w_err <= w_err || !w_in_range;
        end
      end
      if (r_hs) begin
        rd_beats <= rd_beats + 32'd1;
        r_off    <= m_axi_rlast ? 4'd0 : r_off + 4'd1;
      end
      if (r_hs)              r_hold <= 1'b0;
      else if (m_axi_rvalid) r_hold <= 1'b1;
      // A new AR head starts its latency window; later beats of a burst have none.
      if ((ar_push && ar_empty) ||
          (ar_pop && ((ar_cnt != (AR_DEPTH_LOG2+1)'(1)) || ar_push)))
        lat_cnt <= LAT_INIT;
      else if (lat_cnt != 4'd0)
        lat_cnt <= lat_cnt - 4'd1;
    end
  end
endmodule

// File: tb/tb_axi_mem_slave_model.sv
// tb/tb_axi_mem_slave_model.sv - directed self-checking bench for axi_mem_slave_model.
module tb_axi_mem_slave_model;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [5:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr;
  logic [3:0]  awlen, arlen;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready, err_wlast;
  logic [63:0] wdata, rdata;
  logic [7:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [31:0] rd_beats, wr_beats;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] pat [4];

  axi_mem_slave_model #(.MEM_WORDS_LOG2(10)) dut (
    .m_axi_clk(clk), .m_axi_rst(rst),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .err_wlast(err_wlast), .rd_beats(rd_beats), .wr_beats(wr_beats)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_aw(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len);
    int t = 0;
    awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
    #1;
    while (!awready && t < 50) begin @(negedge clk); #1; t++; end
    chk("aw_wait", t < 50, 1'b1);
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic do_ar(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len);
    int t = 0;
    arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
    #1;
    while (!arready && t < 50) begin @(negedge clk); #1; t++; end
    chk("ar_wait", t < 50, 1'b1);
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  task automatic do_w(input logic [63:0] d, input logic [7:0] s, input logic l);
    int t = 0;
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    #1;
    while (!wready && t < 50) begin @(negedge clk); #1; t++; end
    chk("w_wait", t < 50, 1'b1);
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic do_b(input string tag, input logic [5:0] id, input logic [1:0] resp);
    int t = 0;
    #1;
    while (!bvalid && t < 50) begin @(negedge clk); #1; t++; end
    chk({tag, "_wait"}, t < 50, 1'b1);
    chk({tag, "_bid"}, bid, id);
    chk({tag, "_bresp"}, bresp, resp);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic rd_beat(input string tag, input logic [63:0] d, input logic [5:0] id,
                         input logic [1:0] resp, input logic last);
    int t = 0;
    #1;
    while (!rvalid && t < 50) begin @(negedge clk); #1; t++; end
    chk({tag, "_wait"}, t < 50, 1'b1);
    chk({tag, "_rdata"}, rdata, d);
    chk({tag, "_rid"}, rid, id);
    chk({tag, "_rresp"}, rresp, resp);
    chk({tag, "_rlast"}, rlast, last);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    pat[0] = 64'hA5A5_0000_0000_0010; pat[1] = 64'hA5A5_0000_0000_0011;
    pat[2] = 64'hA5A5_0000_0000_0012; pat[3] = 64'hA5A5_0000_0000_0013;
    rst = 1'b1; awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_awready", awready, 0); chk("rst_arready", arready, 0);
    chk("rst_wready", wready, 0);   chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);   chk("rst_rlast", rlast, 0);
    chk("rst_err_wlast", err_wlast, 0);
    chk("rst_rd_beats", rd_beats, 0); chk("rst_wr_beats", wr_beats, 0);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("rel_awready", awready, 1); chk("rel_arready", arready, 1);

    // Write burst of 4 beats
    do_aw(6'd3, 32'h100, 4'd3);
    for (int i = 0; i < 3; i++) do_w(pat[i], 8'hFF, 1'b0);
    wdata = pat[3]; wstrb = 8'hFF; wlast = 1'b1; wvalid = 1'b1;
    #1;
    chk("t1_w3_ready", wready, 1); chk("t1_b_early", bvalid, 0);
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
    #1;
    chk("t1_bvalid_next", bvalid, 1);
    do_b("t1_b", 6'd3, 2'b00);
    #1;
    chk("t1_b_popped", bvalid, 0);
    chk("t1_wr_beats", wr_beats, 4);

    // Read burst with latency 2
    rready = 1'b0;
    arid = 6'd5; araddr = 32'h100; arlen = 4'd3; arvalid = 1'b1;
    #1; chk("t2_arready", arready, 1);
    @(negedge clk); arvalid = 1'b0;
    #1; chk("t2_lat_c1", rvalid, 0);
    @(negedge clk); #1; chk("t2_lat_c2", rvalid, 0);
    @(negedge clk); #1; chk("t2_lat_c3", rvalid, 1);
    rd_beat("t2_b0", pat[0], 6'd5, 2'b00, 1'b0);
    #1; chk("t2_hold_valid", rvalid, 1); chk("t2_hold_data", rdata, pat[1]);
    @(negedge clk);
    for (int i = 1; i < 4; i++) rd_beat("t2_b", pat[i], 6'd5, 2'b00, i == 3);
    #1; chk("t2_rvalid_end", rvalid, 0); chk("t2_rd_beats", rd_beats, 4);

    // Fill AR queue, pop one, refill through the wrap
    for (int k = 0; k < 8; k++) begin
      arid = 6'(k); araddr = 32'h100; arlen = 4'd0; arvalid = 1'b1;
      #1; chk("t3_fill_ready", arready, 1);
      @(negedge clk);
    end
    arvalid = 1'b0;
    #1; chk("t3_full", arready, 0);
    @(negedge clk);
    rd_beat("t3_first", pat[0], 6'd0, 2'b00, 1'b1);
    #1; chk("t3_after_pop", arready, 1);
    arid = 6'd8; araddr = 32'h100; arlen = 4'd0; arvalid = 1'b1;
    @(negedge clk); arvalid = 1'b0;
    #1; chk("t3_full_again", arready, 0);
    for (int k = 1; k < 9; k++) rd_beat("t3_drain", pat[0], 6'(k), 2'b00, 1'b1);
    #1; chk("t3_empty", rvalid, 0); chk("t3_rd_beats", rd_beats, 13);

    // W ahead of AW, partial strobe
    do_aw(6'd9, 32'h200, 4'd0);
    do_w(64'h1122_3344_5566_7788, 8'hFF, 1'b1);
    do_b("t4_full", 6'd9, 2'b00);
    wdata = 64'hAAAA_BBBB_CCCC_DDDD; wstrb = 8'h0F; wlast = 1'b1; wvalid = 1'b1;
    #1; chk("t4_no_aw0", wready, 0);
    @(negedge clk); #1; chk("t4_no_aw1", wready, 0);
    awid = 6'd10; awaddr = 32'h200; awlen = 4'd0; awvalid = 1'b1;
    @(negedge clk); awvalid = 1'b0;
    #1; chk("t4_after_aw", wready, 1);
    @(negedge clk); wvalid = 1'b0; wlast = 1'b0;
    do_b("t4_part", 6'd10, 2'b00);
    do_ar(6'd11, 32'h200, 4'd0);
    rd_beat("t4_rd", 64'h1122_3344_CCCC_DDDD, 6'd11, 2'b00, 1'b1);

    // Out-of-range accesses (1024 words -> 0x2000 is the first bad byte address)
    do_aw(6'd1, 32'h0, 4'd0);
    do_w(64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1);
    do_b("t5_w0", 6'd1, 2'b00);
    do_aw(6'd2, 32'h2000, 4'd1);
    do_w(64'hDEAD_DEAD_DEAD_DEAD, 8'hFF, 1'b0);
    do_w(64'hBEEF_BEEF_BEEF_BEEF, 8'hFF, 1'b1);
    do_b("t5_oor", 6'd2, 2'b10);
    do_aw(6'd12, 32'h1FF8, 4'd1);
    do_w(64'h5555_5555_5555_5555, 8'hFF, 1'b0);
    do_w(64'h6666_6666_6666_6666, 8'hFF, 1'b1);
    do_b("t5_straddle", 6'd12, 2'b10);
    do_ar(6'd3, 32'h2000, 4'd1);
    rd_beat("t5_r0", 64'h0, 6'd3, 2'b10, 1'b0);
    rd_beat("t5_r1", 64'h0, 6'd3, 2'b10, 1'b1);
    do_ar(6'd4, 32'h0, 4'd0);
    rd_beat("t5_word0", 64'h0123_4567_89AB_CDEF, 6'd4, 2'b00, 1'b1);

    // Early wlast, then reset in the middle of a read burst
    do_aw(6'd6, 32'h300, 4'd3);
    #1; chk("t6_err_before", err_wlast, 0);
    do_w(64'h1, 8'hFF, 1'b0);
    do_w(64'h2, 8'hFF, 1'b1);
    #1; chk("t6_err_set", err_wlast, 1);
    do_w(64'h3, 8'hFF, 1'b0);
    do_w(64'h4, 8'hFF, 1'b1);
    do_b("t6_b", 6'd6, 2'b00);
    #1; chk("t6_err_sticky", err_wlast, 1); chk("t6_wr_beats", wr_beats, 15);
    do_ar(6'd7, 32'h100, 4'd3);
    rd_beat("t6_r0", pat[0], 6'd7, 2'b00, 1'b0);
    rd_beat("t6_r1", pat[1], 6'd7, 2'b00, 1'b0);
    #1; chk("t6_rd_beats", rd_beats, 19); chk("t6_mid_rvalid", rvalid, 1);
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    #1;
    chk("t6_rst_rvalid", rvalid, 0); chk("t6_rst_bvalid", bvalid, 0);
    chk("t6_rst_arready", arready, 0); chk("t6_rst_err", err_wlast, 0);
    chk("t6_rst_rd_beats", rd_beats, 0); chk("t6_rst_wr_beats", wr_beats, 0);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("t6_rel_arready", arready, 1);
    repeat (4) @(negedge clk);
    #1; chk("t6_ar_empty", rvalid, 0); chk("t6_b_empty", bvalid, 0);
    chk("t6_w_empty", wready, 0);
    do_ar(6'd8, 32'h100, 4'd0);
    rd_beat("t6_post", pat[0], 6'd8, 2'b00, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_mem_slave_model.md
Name: axi_mem_slave_model

Overview:
- Parametrised single-clock AXI3-style slave memory model for the decoder testbench; serves DPB/reference-picture traffic from the decoder's AXI master.
- Successor to the fixed 64-bit DDR model, generalised in data width, memory depth, outstanding-request depth and read latency.
- Adds behaviour the earlier model lacks: W gated on AW, real B channel with ID echo, RID echo, range checking with SLVERR, protocol error flags, and beat counters.

Parameters:
- DATA_W, 64, data bus width in bits; power of 2, 32..256.
- ADDR_W, 32, byte address width.
- ID_W, 6, AXI ID width.
- MEM_WORDS_LOG2, 20, log2 of memory size in DATA_W-bit words.
- AR_DEPTH_LOG2, 3, log2 of AR queue depth.
- AW_DEPTH_LOG2, 3, log2 of AW queue depth; the B queue has the same depth.
- RD_LATENCY, 2, minimum cycles from a burst reaching the AR queue head to its first rvalid; range 1..15.

Ports:
- m_axi_clk  in  1  single clock for all channels.
- m_axi_rst  in  1  synchronous reset, active-high.
- m_axi_awid/awaddr/awlen/awvalid  in  ID_W/ADDR_W/4/1  write address channel.
- m_axi_awready  out  1  AW accept.
- m_axi_wdata/wstrb/wlast/wvalid  in  DATA_W/DATA_W/8/1/1  write data channel.
- m_axi_wready  out  1  W accept.
- m_axi_bid/bresp/bvalid  out  ID_W/2/1  write response channel.
- m_axi_bready  in  1  B accept.
- m_axi_arid/araddr/arlen/arvalid  in  ID_W/ADDR_W/4/1  read address channel.
- m_axi_arready  out  1  AR accept.
- m_axi_rid/rdata/rresp/rlast/rvalid  out  ID_W/DATA_W/2/1/1  read data channel.
- m_axi_rready  in  1  R accept.
- err_wlast  out  1  sticky: wlast disagrees with awlen.
- rd_beats, wr_beats  out  32/32  handshaked beat counters.

Behaviour:
- Reset: all FIFOs emptied, burst offsets 0. awready, wready, arready, bvalid, rvalid, rlast, err_wlast all 0. Counters 0. Memory contents preserved. Reset mid-burst abandons the burst; no B response is issued for it.
- Addressing:
  - INCR bursts only; awsize/arsize implied full width.
  - Word index = (addr >> log2(DATA_W/8)) + offset.
  - In range when index < 2**MEM_WORDS_LOG2.
- Queues: AW, AR and B are circular FIFOs with an extra wrap bit on the pointers. Full means pointer MSBs differ and low bits are equal. Push and pop in the same cycle are legal, and occupancy is unchanged. A push while full cannot occur because ready is low.
- arready = !ar_full, registered one cycle after reset release. awready = !aw_full, same rule.
- Write path:
  - wready = !aw_empty && !(b_full && current beat is last). W beats are never accepted ahead of their AW.
  - On a W handshake with the word in range, write the bytes enabled by wstrb. Out of range: no write, and the burst's bresp becomes SLVERR (2'b10), sticky for that burst.
  - Beat at offset == awlen:
    - pop AW, push {awid, resp} to B, reset offset to 0;
    - if wlast is 0, set err_wlast.
  - wlast=1 on any earlier beat also sets err_wlast; the burst still terminates at awlen.
- B channel:
  - bvalid = !b_empty; bid/bresp come from the queue head; pop on bvalid && bready.
  - The earliest bvalid is the cycle after the last W handshake.
- Read path:
  - Latency counter loads RD_LATENCY when a new entry becomes the AR head: push into an empty queue, or pop with a non-empty remainder.
  - Counter decrements to 0; rvalid = !ar_empty && counter==0. Subsequent beats of a burst have no latency.
  - rdata = memory word at the current index, or 0 if out of range. rresp = OKAY, or SLVERR when out of range. rid = head arid. rlast = (offset == arlen).
  - All R outputs are held stable while rvalid && !rready.
  - On a handshake with rlast, pop AR and reset the offset.
- Read/write collision: a read of a word written in the same cycle returns the old data.
- Counters: increment on every R / W handshake; wrap at 2**32.

Optional Feature:
- Macro AXI_MEM_RAND_STALL_EN. When defined, a 16-bit LFSR (seed 16'hACE1, reloaded at reset) gates arready, awready, wready and rvalid. Each signal is ANDed with its own distinct LFSR bit, giving about 50% stalls while keeping the stall pattern deterministic. Once rvalid has been asserted it is never deasserted; the gating applies only when presenting a new beat.
- When undefined, no gating.

Test Plan:
- AW addr=0x100 len=3 then 4 W beats with wstrb all ones and an incrementing pattern -> one B with bid=awid, bresp=00, issued the cycle after the 4th W; wr_beats=4.
- AR addr=0x100 len=3 id=5, RD_LATENCY=2 -> first rvalid 2 cycles after the burst reaches the AR head; 4 beats matching the written data, rid=5, rlast on beat 4 only; rd_beats=4.
- Fill AR with 8 requests while holding rready=0 -> arready drops after the 8th; one pop restores it, with the wrap bit exercised.
- W presented before AW -> wready stays 0 until AW accepted; wstrb=0x0F writes only the low 4 bytes.
- awaddr beyond 2**MEM_WORDS_LOG2 words -> bresp=10, memory unchanged; read of same address gives rdata=0, rresp=10.
- wlast on beat 2 of a len=3 burst, plus reset asserted mid read burst -> err_wlast=1 and stays set; after reset all valids are 0 and the queues are empty.
